// File: rtl/game_mode_select.sv
// Menu / game-mode sequencer: turns synchronized key levels into the game mode
// and menu cursor, inserting a mode-0 settle gap on every game entry and exit.
module game_mode_select #(
  parameter int NUM_GAMES     = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iKeyUp,
  input  logic       iKeyDown,
  input  logic       iKeySelect,
  input  logic       iKeyBack,
  input  logic       iGameDone,
  output logic [1:0] oGameMode,
  output logic [1:0] oCursor,
  output logic       oGameStart,
  output logic       oBusy
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [1:0]    MAX_CUR  = 2'(NUM_GAMES);

  typedef enum logic [1:0] {MENU, ARM, PLAY, EXIT} state_t;

  state_t        state, nextState;
  logic [CW-1:0] cnt, nextCnt;
  logic [1:0]    cursor, nextCursor;
  logic          upPrev, downPrev, selPrev, backPrev;
  logic          upEdge, downEdge, selEdge, backEdge;

  assign upEdge   = iKeyUp     & ~upPrev;
  assign downEdge = iKeyDown   & ~downPrev;
  assign selEdge  = iKeySelect & ~selPrev;
  assign backEdge = iKeyBack   & ~backPrev;
  assign oCursor  = cursor;

  always_comb begin
    nextState  = state;
    nextCnt    = cnt;
    nextCursor = cursor;
    case (state)
      MENU: begin
        // Select wins over cursor movement in the same cycle
        if (selEdge) begin
          nextState = ARM;
          nextCnt   = CNT_LOAD;
        end else if (upEdge && !downEdge) begin
          nextCursor = (cursor == MAX_CUR) ? 2'd1 : cursor + 2'd1;
        end else if (downEdge && !upEdge) begin
          nextCursor = (cursor == 2'd1) ? MAX_CUR : cursor - 2'd1;
        end
      end
      ARM: begin
        if (cnt == CNT_ZERO) nextState = PLAY;
        else                 nextCnt   = cnt - CNT_ONE;
      end
      PLAY: begin
        if (iGameDone || backEdge) begin
          nextState = EXIT;
          nextCnt   = CNT_LOAD;
        end
      end
      EXIT: begin
        if (cnt == CNT_ZERO) nextState = MENU;
        else                 nextCnt   = cnt - CNT_ONE;
      end
      default: nextState = MENU;
    endcase
  end

  // Outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= MENU;
      cnt        <= '0;
      cursor     <= 2'd1;
      upPrev     <= 1'b1;
      downPrev   <= 1'b1;
      selPrev    <= 1'b1;
      backPrev   <= 1'b1;
      oGameMode  <= 2'd0;
      oGameStart <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      state      <= nextState;
      cnt        <= nextCnt;
      cursor     <= nextCursor;
      upPrev     <= iKeyUp;
      downPrev   <= iKeyDown;
      selPrev    <= iKeySelect;
      backPrev   <= iKeyBack;
      oGameMode  <= (nextState == PLAY) ? nextCursor : 2'd0;
      oGameStart <= (nextState == PLAY) && (state != PLAY);
      oBusy      <= (nextState == ARM) || (nextState == EXIT);
    end
  end

endmodule

// File: tb/tb_game_mode_select.sv
// Directed bench for game_mode_select; checks {mode, cursor, start, busy}.
module tb_game_mode_select;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iKeyUp = 1'b0, iKeyDown = 1'b0, iKeySelect = 1'b0, iKeyBack = 1'b0;
  logic       iGameDone = 1'b0;
  logic [1:0] oGameMode, oCursor;
  logic       oGameStart, oBusy;
  int         nCmp = 0;
  int         nErr = 0;

  game_mode_select #(.NUM_GAMES(2), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .iKeyUp(iKeyUp), .iKeyDown(iKeyDown),
    .iKeySelect(iKeySelect), .iKeyBack(iKeyBack), .iGameDone(iGameDone),
    .oGameMode(oGameMode), .oCursor(oCursor), .oGameStart(oGameStart), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  // Observed vector is {mode[1:0], cursor[1:0], start, busy}.
  wire [5:0] obs = {oGameMode, oCursor, oGameStart, oBusy};

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    {iKeyUp, iKeyDown, iKeySelect, iKeyBack, iGameDone} = '0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step();
  endtask

  // Press select in MENU and advance until the first PLAY cycle.
  task automatic enterPlay();
    iKeySelect = 1'b1; step();
    iKeySelect = 1'b0; step(4);
  endtask

  task automatic test_reset();
    {iKeyUp, iKeyDown, iKeyBack, iGameDone} = '0;
    iKeySelect = 1'b1;
    reset = 1'b1;
    step(3);
    nCmp++; if (obs !== 6'b00_01_0_0) begin nErr++; $display("FAIL reset_state got %b want %b", obs, 6'b00_01_0_0); end
    reset = 1'b0;
    step(3);
    nCmp++; if (obs !== 6'b00_01_0_0) begin nErr++; $display("FAIL held_select_no_arm got %b want %b", obs, 6'b00_01_0_0); end
    iKeySelect = 1'b0; step();
    iKeySelect = 1'b1; step();
    nCmp++; if (obs !== 6'b00_01_0_1) begin nErr++; $display("FAIL repress_arms got %b want %b", obs, 6'b00_01_0_1); end
  endtask

  task automatic test_cursor();
    logic [1:0] expCur [6];
    expCur = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
    doReset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3)       iKeyUp = 1'b1;
      else if (i < 5)  iKeyDown = 1'b1;
      else             {iKeyUp, iKeyDown} = 2'b11;
      step();
      nCmp++; if (obs !== {2'd0, expCur[i], 2'b00}) begin nErr++; $display("FAIL cursor_move_%0d got %b want %b", i, obs, {2'd0, expCur[i], 2'b00}); end
      {iKeyUp, iKeyDown} = 2'b00;
      step();
    end
  endtask

  task automatic test_play_entry();
    doReset();
    iKeyUp = 1'b1; step(); iKeyUp = 1'b0; step();
    iKeySelect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      iKeySelect = 1'b0;
      nCmp++; if (obs !== 6'b00_10_0_1) begin nErr++; $display("FAIL arm_cycle_%0d got %b want %b", i, obs, 6'b00_10_0_1); end
    end
    step();
    nCmp++; if (obs !== 6'b10_10_1_0) begin nErr++; $display("FAIL play_first got %b want %b", obs, 6'b10_10_1_0); end
    iKeyUp = 1'b1; iKeySelect = 1'b1; step();
    nCmp++; if (obs !== 6'b10_10_0_0) begin nErr++; $display("FAIL play_hold got %b want %b", obs, 6'b10_10_0_0); end
    {iKeyUp, iKeySelect} = 2'b00;
  endtask

  task automatic test_exit();
    doReset();
    enterPlay();
    nCmp++; if (obs !== 6'b01_01_1_0) begin nErr++; $display("FAIL play_mode1 got %b want %b", obs, 6'b01_01_1_0); end
    iGameDone = 1'b1; iKeyBack = 1'b1; step();
    iGameDone = 1'b0; iKeyBack = 1'b0;
    nCmp++; if (obs !== 6'b00_01_0_1) begin nErr++; $display("FAIL done_exit got %b want %b", obs, 6'b00_01_0_1); end
    step(3);
    nCmp++; if (obs !== 6'b00_01_0_1) begin nErr++; $display("FAIL exit_last got %b want %b", obs, 6'b00_01_0_1); end
    step();
    nCmp++; if (obs !== 6'b00_01_0_0) begin nErr++; $display("FAIL back_in_menu got %b want %b", obs, 6'b00_01_0_0); end
    // cursor moves again only if we are really back in MENU
    iKeyUp = 1'b1; step(); iKeyUp = 1'b0; step();
    nCmp++; if (obs !== 6'b00_10_0_0) begin nErr++; $display("FAIL menu_live got %b want %b", obs, 6'b00_10_0_0); end
    enterPlay();
    iKeyBack = 1'b1; step();
    iKeyBack = 1'b0;
    nCmp++; if (obs !== 6'b00_10_0_1) begin nErr++; $display("FAIL back_exit got %b want %b", obs, 6'b00_10_0_1); end
    step(4);
    nCmp++; if (obs !== 6'b00_10_0_0) begin nErr++; $display("FAIL back_to_menu got %b want %b", obs, 6'b00_10_0_0); end
  endtask

  task automatic test_arm_ignore();
    doReset();
    iKeyBack = 1'b1; step(); iKeyBack = 1'b0; step();
    nCmp++; if (obs !== 6'b00_01_0_0) begin nErr++; $display("FAIL menu_back_ignored got %b want %b", obs, 6'b00_01_0_0); end
    iKeySelect = 1'b1; step();
    iKeySelect = 1'b0; step();
    iKeyBack = 1'b1; iKeyUp = 1'b1; iGameDone = 1'b1; step();
    iGameDone = 1'b0; iKeySelect = 1'b1; step();
    nCmp++; if (obs !== 6'b00_01_0_1) begin nErr++; $display("FAIL arm_keys_ignored got %b want %b", obs, 6'b00_01_0_1); end
    step();
    nCmp++; if (obs !== 6'b01_01_1_0) begin nErr++; $display("FAIL arm_on_time got %b want %b", obs, 6'b01_01_1_0); end
    // keys held across ARM must not fire once PLAY begins
    step(2);
    nCmp++; if (obs !== 6'b01_01_0_0) begin nErr++; $display("FAIL held_no_fire got %b want %b", obs, 6'b01_01_0_0); end
    {iKeyBack, iKeyUp, iKeySelect} = 3'b000;
  endtask

  task automatic test_reset_in_play();
    doReset();
    iKeyDown = 1'b1; step(); iKeyDown = 1'b0; step();
    enterPlay();
    nCmp++; if (obs !== 6'b10_10_1_0) begin nErr++; $display("FAIL pre_reset_play got %b want %b", obs, 6'b10_10_1_0); end
    reset = 1'b1; step();
    nCmp++; if (obs !== 6'b00_01_0_0) begin nErr++; $display("FAIL reset_in_play got %b want %b", obs, 6'b00_01_0_0); end
    reset = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_play_entry();
    test_exit();
    test_arm_ignore();
    test_reset_in_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
